// File: rtl/conv3x3_addtree_seq_pkg.sv
// Shared types and widths for the 3x3 streaming window-sum block.
// The RELU option (macro CONV3X3_RELU_EN) is resolved in the top module.
package conv3x3_addtree_seq_pkg;

    localparam int PIX_W = 8;
    localparam int SUM_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic signed [SUM_W-1:0] sext_pix(input logic signed [PIX_W-1:0] p);
        return {{(SUM_W-PIX_W){p[PIX_W-1]}}, p};
    endfunction

endpackage

// File: rtl/cal_addtree_int8_x9.sv
// Nine-input signed adder tree with ADDTREE_LAT register stages.
// Three 3-input partial sums, then a final 3-input add, then extra delay stages.
module cal_addtree_int8_x9
    import conv3x3_addtree_seq_pkg::*;
#(
    parameter int ADDTREE_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [PIX_W-1:0] din [9],
    output logic signed [SUM_W-1:0] sum_out
);

    logic signed [SUM_W-1:0] part_d [3];

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            part_d[k] = sext_pix(din[3*k]) + sext_pix(din[3*k+1]) + sext_pix(din[3*k+2]);
        end
    end

    generate
        if (ADDTREE_LAT == 0) begin : g_comb
            assign sum_out = part_d[0] + part_d[1] + part_d[2];
        end else begin : g_pipe
            logic signed [SUM_W-1:0] part_p0_q [3];
            logic signed [SUM_W-1:0] total_d;

            // stage p0: partial sums registered
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < 3; k++) part_p0_q[k] <= '0;
                end else begin
                    part_p0_q <= part_d;
                end
            end

            assign total_d = part_p0_q[0] + part_p0_q[1] + part_p0_q[2];

            if (ADDTREE_LAT == 1) begin : g_out1
                assign sum_out = total_d;
            end else begin : g_outn
                logic signed [SUM_W-1:0] total_p_q [ADDTREE_LAT-1];

                // stages p1..: final sum and trailing delay registers
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int k = 0; k < ADDTREE_LAT-1; k++) total_p_q[k] <= '0;
                    end else begin
                        total_p_q[0] <= total_d;
                        for (int k = 1; k < ADDTREE_LAT-1; k++) total_p_q[k] <= total_p_q[k-1];
                    end
                end

                assign sum_out = total_p_q[ADDTREE_LAT-2];
            end
        end
    endgenerate

endmodule

// File: rtl/conv3x3_addtree_seq.sv
// Streaming 3x3 window-sum over a raster frame: line buffers, window regs, adder tree.
// Define CONV3X3_RELU_EN to clamp negative window sums to zero.
module conv3x3_addtree_seq
    import conv3x3_addtree_seq_pkg::*;
#(
    parameter int IMG_W       = 28,
    parameter int IMG_H       = 28,
    parameter int ADDTREE_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pix_valid,
    input  logic signed [PIX_W-1:0] pix_data,
    output logic                    pix_ready,
    output logic                    sum_valid,
    output logic signed [SUM_W-1:0] sum_data,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_t                  state_q;
    logic                    pix_ready_q, busy_q, frame_done_q;
    logic [RW-1:0]           row_q, row_d;
    logic [CW-1:0]           col_q, col_d;
    logic                    accept, last_pix, win_done;
    logic signed [PIX_W-1:0] lb0_q [IMG_W];
    logic signed [PIX_W-1:0] lb0_d [IMG_W];
    logic signed [PIX_W-1:0] lb1_q [IMG_W];
    logic signed [PIX_W-1:0] lb1_d [IMG_W];
    logic signed [PIX_W-1:0] win_q [9];
    logic signed [PIX_W-1:0] win_d [9];
    logic [ADDTREE_LAT:0]    vld_q, vld_d;
    logic signed [SUM_W-1:0] tree_sum, sum_data_q, sum_data_d;
    logic                    sum_valid_q, sum_valid_d;

    function automatic logic signed [SUM_W-1:0] post_proc(input logic signed [SUM_W-1:0] s);
`ifdef CONV3X3_RELU_EN
        return s[SUM_W-1] ? '0 : s;
`else
        return s;
`endif
    endfunction

    assign accept   = pix_valid & pix_ready_q;
    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign win_done = accept && (row_q >= ROW_TWO) && (col_q >= COL_TWO);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (state_q == ST_IDLE && start) begin
            row_d = '0;
            col_d = '0;
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Window columns shift left; the new right column is {two rows up, one row up, current}.
    always_comb begin
        lb0_d = lb0_q;
        lb1_d = lb1_q;
        win_d = win_q;
        if (accept) begin
            lb0_d[0] = pix_data;
            lb1_d[0] = lb0_q[IMG_W-1];
            for (int i = 1; i < IMG_W; i++) begin
                lb0_d[i] = lb0_q[i-1];
                lb1_d[i] = lb1_q[i-1];
            end
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            win_d[2] = lb1_q[IMG_W-1];
            win_d[5] = lb0_q[IMG_W-1];
            win_d[8] = pix_data;
        end
    end

    always_comb begin
        vld_d[0] = win_done;
        for (int i = 1; i <= ADDTREE_LAT; i++) vld_d[i] = vld_q[i-1];
        sum_valid_d = vld_q[ADDTREE_LAT];
        sum_data_d  = vld_q[ADDTREE_LAT] ? post_proc(tree_sum) : sum_data_q;
    end

    always_ff @(posedge clk) begin
        lb0_q <= lb0_d;
        lb1_q <= lb1_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= '0;
            col_q       <= '0;
            vld_q       <= '0;
            sum_valid_q <= 1'b0;
            sum_data_q  <= '0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            vld_q       <= vld_d;
            sum_valid_q <= sum_valid_d;
            sum_data_q  <= sum_data_d;
            win_q       <= win_d;
        end
    end

    // DRAIN ends once the final sum has been presented and nothing remains in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pix_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_FILL;
                        pix_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (accept && last_pix) begin
                        state_q     <= ST_DRAIN;
                        pix_ready_q <= 1'b0;
                    end else if (accept && row_q == ROW_TWO && col_q == COL_TWO) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && last_pix) begin
                        state_q     <= ST_DRAIN;
                        pix_ready_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (sum_valid_q && vld_q == '0) begin
                        state_q      <= ST_DONE;
                        frame_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    pix_ready_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    cal_addtree_int8_x9 #(
        .ADDTREE_LAT(ADDTREE_LAT)
    ) u_addtree (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (win_q),
        .sum_out(tree_sum)
    );

    assign pix_ready  = pix_ready_q;
    assign sum_valid  = sum_valid_q;
    assign sum_data   = sum_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_addtree_seq.sv
// Directed bench for conv3x3_addtree_seq on a 4x4 frame with a 2-stage adder tree.
module tb_conv3x3_addtree_seq;

    localparam int W   = 4;
    localparam int H   = 4;
    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n, start, pix_valid;
    logic signed [7:0] pix_data;
    logic              pix_ready, sum_valid, busy, frame_done;
    logic signed [9:0] sum_data;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acc_cnt;
    int got_sum[$];
    int got_cyc[$];
    int exp_cyc[$];
    int fd_cyc[$];

    conv3x3_addtree_seq #(
        .IMG_W(W), .IMG_H(H), .ADDTREE_LAT(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .sum_valid(sum_valid),
        .sum_data(sum_data), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sum_valid) begin
            got_sum.push_back(int'(sum_data));
            got_cyc.push_back(cyc);
        end
        if (frame_done) fd_cyc.push_back(cyc);
    end

    task automatic clear_log();
        got_sum.delete();
        got_cyc.delete();
        exp_cyc.delete();
        fd_cyc.delete();
        acc_cnt = 0;
    endtask

    // Drives one frame; completing pixels predict their sum_valid cycle (accept edge + LAT + 1).
    task automatic run_frame(input int vals[16], input bit gap, input bit start_mid);
        int  k = 0;
        int  step = 0;
        int  acc_edge;
        bit  acc;
        clear_log();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (k < 16 && step < 200) begin
            pix_valid = gap ? (step % 2 == 0) : 1'b1;
            pix_data  = 8'(vals[k]);
            start     = start_mid && (k == 12);
            acc       = pix_valid && pix_ready;
            acc_edge  = cyc + 1;
            @(posedge clk); #1;
            if (acc) begin
                if ((k / W) >= 2 && (k % W) >= 2) exp_cyc.push_back(acc_edge + LAT + 1);
                k++;
                acc_cnt++;
            end
            step++;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        step = 0;
        while (fd_cyc.size() == 0 && step < 60) begin
            @(posedge clk); #1;
            step++;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL reset_pix_ready: got %b want 0", pix_ready); end
        vectors++; if (sum_valid !== 1'b0) begin miscompares++; $display("FAIL reset_sum_valid: got %b want 0", sum_valid); end
        vectors++; if (sum_data !== 10'sd0) begin miscompares++; $display("FAIL reset_sum_data: got %0d want 0", sum_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    endtask

    task automatic test_ones();
        int v[16];
        int want[4] = '{9, 9, 9, 9};
        for (int i = 0; i < 16; i++) v[i] = 1;
        run_frame(v, 1'b0, 1'b0);
        vectors++; if (got_sum.size() !== 4) begin miscompares++; $display("FAIL ones_count: got %0d want 4", got_sum.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_sum.size() && i < exp_cyc.size()) begin
                vectors++; if (got_sum[i] !== want[i]) begin miscompares++; $display("FAIL ones_sum%0d: got %0d want %0d", i, got_sum[i], want[i]); end
                vectors++; if (got_cyc[i] !== exp_cyc[i]) begin miscompares++; $display("FAIL ones_cyc%0d: got %0d want %0d", i, got_cyc[i], exp_cyc[i]); end
            end
        end
        vectors++;
        if (fd_cyc.size() !== 1 || exp_cyc.size() !== 4) begin
            miscompares++; $display("FAIL ones_frame_done: got %0d pulses want 1", fd_cyc.size());
        end else if (fd_cyc[0] !== exp_cyc[3] + 1) begin
            miscompares++; $display("FAIL ones_frame_done_cyc: got %0d want %0d", fd_cyc[0], exp_cyc[3] + 1);
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ones_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_ramp();
        int v[16];
        int want[4] = '{45, 54, 81, 90};
        for (int i = 0; i < 16; i++) v[i] = i;
        run_frame(v, 1'b0, 1'b0);
        vectors++; if (got_sum.size() !== 4) begin miscompares++; $display("FAIL ramp_count: got %0d want 4", got_sum.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_sum.size()) begin
                vectors++; if (got_sum[i] !== want[i]) begin miscompares++; $display("FAIL ramp_sum%0d: got %0d want %0d", i, got_sum[i], want[i]); end
            end
        end
        vectors++; if (fd_cyc.size() !== 1) begin miscompares++; $display("FAIL ramp_frame_done: got %0d pulses want 1", fd_cyc.size()); end
    endtask

    task automatic test_negative();
        int v[16];
`ifdef CONV3X3_RELU_EN
        int want = 0;
`else
        int want = -9;
`endif
        for (int i = 0; i < 16; i++) v[i] = -1;
        run_frame(v, 1'b0, 1'b0);
        vectors++; if (got_sum.size() !== 4) begin miscompares++; $display("FAIL neg_count: got %0d want 4", got_sum.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_sum.size()) begin
                vectors++; if (got_sum[i] !== want) begin miscompares++; $display("FAIL neg_sum%0d: got %0d want %0d", i, got_sum[i], want); end
            end
        end
    endtask

    task automatic test_gaps();
        int v[16];
        for (int i = 0; i < 16; i++) v[i] = 1;
        run_frame(v, 1'b1, 1'b0);
        vectors++; if (acc_cnt !== 16) begin miscompares++; $display("FAIL gaps_accepted: got %0d want 16", acc_cnt); end
        vectors++; if (got_sum.size() !== 4) begin miscompares++; $display("FAIL gaps_count: got %0d want 4", got_sum.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_sum.size() && i < exp_cyc.size()) begin
                vectors++; if (got_sum[i] !== 9) begin miscompares++; $display("FAIL gaps_sum%0d: got %0d want 9", i, got_sum[i]); end
                vectors++; if (got_cyc[i] !== exp_cyc[i]) begin miscompares++; $display("FAIL gaps_cyc%0d: got %0d want %0d", i, got_cyc[i], exp_cyc[i]); end
            end
        end
        vectors++; if (fd_cyc.size() !== 1) begin miscompares++; $display("FAIL gaps_frame_done: got %0d pulses want 1", fd_cyc.size()); end
    endtask

    task automatic test_start_ignored();
        int v[16];
        for (int i = 0; i < 16; i++) v[i] = 1;
        run_frame(v, 1'b0, 1'b1);
        vectors++; if (got_sum.size() !== 4) begin miscompares++; $display("FAIL startrun_count: got %0d want 4", got_sum.size()); end
        vectors++; if (fd_cyc.size() !== 1) begin miscompares++; $display("FAIL startrun_frame_done: got %0d pulses want 1", fd_cyc.size()); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL startrun_busy_after: got %b want 0", busy); end
        vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL startrun_ready_after: got %b want 0", pix_ready); end
    endtask

    task automatic test_reset_mid();
        int v[16];
        clear_log();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            pix_valid = 1'b1;
            pix_data  = 8'sd1;
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_pix_ready: got %b want 0", pix_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
        vectors++; if (sum_data !== 10'sd0) begin miscompares++; $display("FAIL midrst_sum_data: got %0d want 0", sum_data); end
        vectors++; if (sum_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_sum_valid: got %b want 0", sum_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (got_sum.size() !== 0) begin miscompares++; $display("FAIL midrst_no_sums: got %0d want 0", got_sum.size()); end
        vectors++; if (fd_cyc.size() !== 0) begin miscompares++; $display("FAIL midrst_no_done: got %0d want 0", fd_cyc.size()); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_idle: got busy %b want 0", busy); end
        for (int i = 0; i < 16; i++) v[i] = 1;
        run_frame(v, 1'b0, 1'b0);
        vectors++; if (got_sum.size() !== 4) begin miscompares++; $display("FAIL midrst_new_count: got %0d want 4", got_sum.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_sum.size()) begin
                vectors++; if (got_sum[i] !== 9) begin miscompares++; $display("FAIL midrst_new_sum%0d: got %0d want 9", i, got_sum[i]); end
            end
        end
        vectors++; if (fd_cyc.size() !== 1) begin miscompares++; $display("FAIL midrst_new_done: got %0d pulses want 1", fd_cyc.size()); end
    endtask

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = '0;
        #2 rst_n = 1'b0;
        #1 test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        test_ones();
        test_ramp();
        test_negative();
        test_gaps();
        test_start_ignored();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv3x3_addtree_seq.md
CONV3X3_ADDTREE_SEQ -- requirements
Module: conv3x3_addtree_seq

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning pixels per input row (>=3).
REQ-002 SHALL have parameter IMG_H, default 28, meaning rows per input frame (>=3).
REQ-003 SHALL have parameter ADDTREE_LAT, default 2, meaning register stages inside the 9-input adder tree.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle frame start request.
REQ-007 SHALL have port pix_valid  input  1  pix_data valid this cycle.
REQ-008 SHALL have port pix_data  input  8  signed int8 pixel (product term), raster order.
REQ-009 SHALL have port pix_ready  output  1  block accepts pixel this cycle.
REQ-010 SHALL have port sum_valid  output  1  sum_data valid (one-cycle pulse per window).
REQ-011 SHALL have port sum_data  output  10  signed 3x3 window sum.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse after final window sum.

Function
REQ-014 SHALL implement FSM IDLE -> FILL -> RUN -> DRAIN -> DONE -> IDLE.
REQ-015 IDLE: start=1 -> FILL, row/col counters cleared; start outside IDLE ignored.
REQ-016 Handshake: pixel accepted on edge where pix_valid & pix_ready; pix_ready=1 only in FILL/RUN.
REQ-017 Each accepted pixel SHALL shift into two IMG_W-deep line buffers and a 3x3 window register array.
REQ-018 Col counter wraps IMG_W-1 -> 0 with row increment; row/col advance only on accepted pixels.
REQ-019 FILL -> RUN when accepted pixel has row=2, col=2 (first complete window).
REQ-020 A window is complete when accepted pixel has row>=2 and col>=2; exactly (IMG_H-2)*(IMG_W-2) sums per frame.
REQ-021 Window registers SHALL drive the nine adder-tree inputs; sum_valid SHALL assert ADDTREE_LAT+1 cycles after the accepting edge of a completing pixel.
REQ-022 RUN -> DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1); pix_ready=0 thereafter.
REQ-023 DRAIN SHALL hold ADDTREE_LAT+1 cycles until the last sum_valid, then -> DONE.
REQ-024 DONE SHALL last one cycle with frame_done=1, then -> IDLE.
REQ-025 Gaps in pix_valid SHALL not produce sum_valid; valid tracking uses an ADDTREE_LAT+1 deep shift register.
REQ-026 Sum width: 10-bit signed, two's complement wrap; inputs are int4-range values sign-extended to int8, so no overflow for legal data.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE, pix_ready=0, sum_valid=0, sum_data=0, busy=0, frame_done=0.
REQ-028 Reset SHALL clear counters, window registers and valid shift register; line-buffer contents need not clear.
REQ-029 Reset mid-frame SHALL discard the frame; no sum_valid or frame_done after release until a new start.

Configuration
REQ-030 Macro CONV3X3_RELU_EN defined: sum_data = max(tree_sum, 0), no added latency.
REQ-031 Macro CONV3X3_RELU_EN undefined: sum_data = raw signed tree sum.

Structure
REQ-032 Shared package SHALL hold FSM state encoding, pixel width (8) and sum width (10).
REQ-033 SHALL instantiate one sub-module, cal_addtree_int8_x9, as the adder tree; line buffers inline.

Verification (IMG_W=IMG_H=4, ADDTREE_LAT=2)
REQ-034 start, 16 pixels of +1, pix_valid held high -> 4 sum_valid pulses, sum_data=9 each, frame_done one cycle after fourth.
REQ-035 Pixels 0..15 raster ramp -> sums 45, 54, 81, 90 in order.
REQ-036 All pixels -1: RELU_EN defined -> four sums of 0; undefined -> four sums of -9.
REQ-037 pix_valid toggled 1/0 each cycle -> same four sums as REQ-034, sum_valid never on non-completing cycles.
REQ-038 rst_n pulsed low after 8 pixels accepted -> outputs zero immediately, no sum_valid; new start + 16 pixels -> normal frame.
REQ-039 start asserted during RUN -> ignored, frame completes with exactly 4 sums.
